// File: rtl/jk_drive_seq.sv
// Command sequencer that queues J/K drive commands and replays each for cmd_len+1 cycles.
// Latency: command accepted at edge N into an empty, idle queue drives J/K after edge N+1.
// Backpressure: cmd_ready deasserts combinationally when the queue is full or reset is held.
module jk_drive_seq #(
    parameter int DEPTH = 4,
    parameter int LENW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    input  logic [1:0]      cmd_op,
    input  logic [LENW-1:0] cmd_len,
    output logic            cmd_ready,
    output logic            J,
    output logic            K,
    output logic            busy,
    output logic            done,
    output logic            q_model
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Command storage; contents need no reset because count/pointers gate every read.
    logic [1:0]      op_mem_q  [DEPTH];
    logic [LENW-1:0] len_mem_q [DEPTH];

    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;

    state_t          state_q, state_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic            j_q, j_d;
    logic            k_q, k_d;
    logic            done_q, done_d;
    logic            qm_q, qm_d;

    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    logic [1:0]      head_op;
    logic [LENW-1:0] head_len;

    // Pointer advance with explicit wrap so non-power-of-two depths stay correct.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTRW'(1);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNTW'(DEPTH));
    // Full blocks a push even if a pop frees a slot this cycle; keeps ready free of FSM timing.
    assign cmd_ready  = reset && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign head_op    = op_mem_q[rd_ptr_q];
    assign head_len   = len_mem_q[rd_ptr_q];

    assign J       = j_q;
    assign K       = k_q;
    assign busy    = (state_q == DRIVE);
    assign done    = done_q;
    assign q_model = qm_q;

    // Write the accepted command into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem_q[wr_ptr_q]  <= cmd_op;
            len_mem_q[wr_ptr_q] <= cmd_len;
        end
    end

    // Queue bookkeeping: pointers wrap, count tracks push/pop with simultaneous ops cancelling.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // Sequencer: load head on IDLE or at the end of a drive run, count down otherwise.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        j_d     = j_q;
        k_d     = k_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    j_d     = head_op[1];
                    k_d     = head_op[0];
                    rem_d   = head_len;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (rem_q != '0) begin
                    rem_d = rem_q - LENW'(1);
                end else begin
                    // Last drive cycle of this command: flag completion next cycle.
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        pop   = 1'b1;
                        j_d   = head_op[1];
                        k_d   = head_op[0];
                        rem_d = head_len;
                    end else begin
                        j_d     = 1'b0;
                        k_d     = 1'b0;
                        rem_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                j_d     = 1'b0;
                k_d     = 1'b0;
                rem_d   = '0;
            end
        endcase
    end

    // Shadow of the downstream jk_ff, advanced from the J/K currently on the wires.
    always_comb begin
        qm_d = qm_q;
        case ({j_q, k_q})
            2'b10:   qm_d = 1'b1;
            2'b01:   qm_d = 1'b0;
            2'b11:   qm_d = ~qm_q;
            default: qm_d = qm_q;
        endcase
    end

    // State registers; reset drops any active and queued commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            rem_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            done_q   <= 1'b0;
            qm_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
            qm_q     <= qm_d;
        end
    end

endmodule

// File: tb/tb_jk_drive_seq.sv
module tb_jk_drive_seq;

    localparam int DEPTH = 4;
    localparam int LENW  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic [1:0]      cmd_op;
    logic [LENW-1:0] cmd_len;
    logic            cmd_ready;
    logic            J;
    logic            K;
    logic            busy;
    logic            done;
    logic            q_model;

    always #5 clk = ~clk;

    jk_drive_seq #(.DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .J         (J),
        .K         (K),
        .busy      (busy),
        .done      (done),
        .q_model   (q_model)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per expected drive cycle, flagged on a command's last cycle.
    typedef struct packed {
        logic [1:0] jk;
        logic       last;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    logic ref_q     = 1'b0;
    logic done_exp  = 1'b0;
    bit   mon_en    = 1'b0;
    int   acc_cnt   = 0;

    // Reference downstream jk_ff sharing clock and reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_q <= 1'b0;
        end else begin
            case ({J, K})
                2'b10:   ref_q <= 1'b1;
                2'b01:   ref_q <= 1'b0;
                2'b11:   ref_q <= ~ref_q;
                default: ref_q <= ref_q;
            endcase
        end
    end

    // Record accepted commands as expected drive cycles.
    always @(posedge clk) begin
        if (reset && cmd_valid && cmd_ready) begin
            acc_cnt++;
            for (int i = 0; i <= int'(cmd_len); i++) begin
                sb.push_back({cmd_op, (i == int'(cmd_len))});
            end
        end
    end

    always @(negedge reset) begin
        sb.delete();
        done_exp = 1'b0;
    end

    // Compare DUT outputs against the scoreboard and reference flop every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("sb_done", done, done_exp);
            if (busy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_busy", 1, 0);
                    done_exp = 1'b0;
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_jk", {J, K}, mon_e.jk);
                    done_exp = mon_e.last;
                end
            end else begin
                chk("sb_idle_jk", {J, K}, 2'b00);
                done_exp = 1'b0;
            end
            chk("sb_qmodel", q_model, ref_q);
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [LENW-1:0] len);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_len   = len;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy || sb.size() != 0) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int         nb;
        int         nd;
        int         nq;
        logic [3:0] qs;
        logic [5:0] jks;
        logic [7:0] busy_v;
        logic [7:0] done_v;
        logic       any_act;
        logic [1:0]      r_op;
        logic [LENW-1:0] r_len;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_J", J, 0);
        chk("rst_K", K, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_qmodel", q_model, 0);
        chk("rst_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_no_accept", acc_cnt, 0);
        chk("rst_no_busy", busy, 0);

        // Single set: accept at edge 1 after release
        reset   = 1'b1;
        mon_en  = 1'b1;
        cmd_op  = 2'b10;
        cmd_len = '0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("set_e1_J", J, 0);
        chk("set_e1_busy", busy, 0);
        @(negedge clk);
        chk("set_e2_JK", {J, K}, 2'b10);
        chk("set_e2_busy", busy, 1);
        @(negedge clk);
        chk("set_e3_JK", {J, K}, 2'b00);
        chk("set_e3_done", done, 1);
        chk("set_e3_qmodel", q_model, 1);
        chk("set_e3_busy", busy, 0);
        @(negedge clk);
        chk("set_e4_done", done, 0);

        // Toggle run from q_model=0
        push_cmd(2'b01, 4'd0);
        wait_idle();
        chk("tog_q0", q_model, 0);
        push_cmd(2'b11, 4'd3);
        nb = 0; nd = 0; nq = 0; qs = '0;
        any_act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (any_act) begin
                qs = {qs[2:0], q_model};
                nq++;
            end
            any_act = busy;
            if (busy) nb++;
            if (done) nd++;
        end
        chk("tog_busy_cycles", nb, 4);
        chk("tog_done_pulses", nd, 1);
        chk("tog_q_samples", nq, 4);
        chk("tog_q_seq", qs, 4'b1010);

        // Back-to-back commands on consecutive edges
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_len   = 4'd1;
        @(posedge clk);
        #1;
        cmd_op  = 2'b01;
        cmd_len = 4'd0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        busy_v = '0; done_v = '0; jks = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            busy_v[i] = busy;
            done_v[i] = done;
            if (busy) jks = {jks[3:0], J, K};
        end
        chk("b2b_busy", busy_v, 8'b0000_0111);
        chk("b2b_jk_seq", jks, 6'b10_10_01);
        chk("b2b_done", done_v, 8'b0000_1100);
        chk("b2b_final_q", q_model, 0);

        // Full FIFO with cmd_valid held high
        wait_idle();
        acc_cnt   = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_len   = 4'd15;
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("full_ready_e%0d", e), cmd_ready, (e < 5) || (e >= 18));
            if (e == 17) begin
                chk("full_accepted", acc_cnt, 5);
                cmd_valid = 1'b0;
            end
        end
        wait_idle();

        // Maximum length: 2^LENW drive cycles
        push_cmd(2'b10, 4'd15);
        nb = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("maxlen_cycles", nb, 16);

        // Reset during DRIVE with commands queued
        wait_idle();
        push_cmd(2'b11, 4'd7);
        push_cmd(2'b10, 4'd7);
        push_cmd(2'b01, 4'd7);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_J", J, 0);
        chk("mid_rst_K", K, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_qmodel", q_model, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_len   = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        any_act   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_act = any_act | J | K | busy | done;
        end
        chk("post_rst_quiet", any_act, 0);

        // Random commands against scoreboard and reference flop
        for (int n = 0; n < 40; n++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_len = ($urandom_range(0, 7) == 0) ? 4'd15 : LENW'($urandom_range(0, 3));
            push_cmd(r_op, r_len);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        chk("rand_sb_empty", sb.size(), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
